// File: rtl/dm_obi_initiator_if.sv
// Command/response stream plus OBI manager bus of dm_obi_initiator.
// master is the adapter's own view; slave is the view of the logic around it.
interface dm_obi_initiator_if #(
  parameter int unsigned IdWidth  = 1,
  parameter int unsigned BusWidth = 32
);
  logic                  cmd_valid_i;
  logic                  cmd_ready_o;
  logic                  cmd_we_i;
  logic [BusWidth-1:0]   cmd_addr_i;
  logic [BusWidth/8-1:0] cmd_be_i;
  logic [BusWidth-1:0]   cmd_wdata_i;

  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [BusWidth-1:0]   rsp_rdata_o;
  logic                  rsp_err_o;

  logic                  obi_req_o;
  logic                  obi_gnt_i;
  logic [BusWidth-1:0]   obi_addr_o;
  logic                  obi_we_o;
  logic [BusWidth/8-1:0] obi_be_o;
  logic [BusWidth-1:0]   obi_wdata_o;
  logic [IdWidth-1:0]    obi_aid_o;
  logic                  obi_rvalid_i;
  logic [BusWidth-1:0]   obi_rdata_i;
  logic                  obi_err_i;
  logic [IdWidth-1:0]    obi_rid_i;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_addr_i, cmd_be_i, cmd_wdata_i, rsp_ready_i,
           obi_gnt_i, obi_rvalid_i, obi_rdata_i, obi_err_i, obi_rid_i,
    output cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
           obi_req_o, obi_addr_o, obi_we_o, obi_be_o, obi_wdata_o, obi_aid_o
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_addr_i, cmd_be_i, cmd_wdata_i, rsp_ready_i,
           obi_gnt_i, obi_rvalid_i, obi_rdata_i, obi_err_i, obi_rid_i,
    input  cmd_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
           obi_req_o, obi_addr_o, obi_we_o, obi_be_o, obi_wdata_o, obi_aid_o
  );
endinterface

// File: rtl/dm_obi_initiator.sv
// OBI manager adapter: cmd stream -> OBI address phase, OBI response phase -> buffered rsp stream.
// A command is only accepted when response-buffer space is reserved for it.
module dm_obi_initiator #(
  parameter int unsigned IdWidth        = 1,
  parameter int unsigned BusWidth       = 32,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  dm_obi_initiator_if.master bus,
  input  logic               clr_err_i,
  output logic               proto_err_o,
  output logic               idle_o
);
  localparam int unsigned BeWidth  = BusWidth / 8;
  localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1);
  localparam int unsigned PtrWidth = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam logic [CntWidth-1:0] MaxCnt  = CntWidth'(MaxOutstanding);
  localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(MaxOutstanding - 1);

  if (MaxOutstanding < 1 || MaxOutstanding > (2 ** IdWidth)) begin : gen_param_check
    $error("MaxOutstanding must be within 1 .. 2**IdWidth");
  end

  logic                r_req, r_we;
  logic [BusWidth-1:0] r_addr, r_wdata;
  logic [BeWidth-1:0]  r_be;
  logic [IdWidth-1:0]  r_aid, r_exp_rid;
  logic [CntWidth-1:0] r_used, r_inflight, r_count;
  logic [PtrWidth-1:0] r_wptr, r_rptr;
  logic                r_proto_err;
  logic [BusWidth-1:0] r_fifo_rdata [MaxOutstanding];
  logic                r_fifo_err   [MaxOutstanding];

  logic                w_cmd_ready, w_accept, w_grant, w_rsp_ok, w_spurious, w_pop, w_err_set;
  logic                w_req_d, w_proto_err_d;
  logic [CntWidth-1:0] w_used_d, w_inflight_d, w_count_d;
  logic [PtrWidth-1:0] w_wptr_d, w_rptr_d;

  always_comb begin
    // used counts from accept to pop, so it bounds everything in flight or buffered
    w_cmd_ready = (!r_req || bus.obi_gnt_i) && (r_used < MaxCnt);
    w_accept    = bus.cmd_valid_i && w_cmd_ready;
    w_grant     = r_req && bus.obi_gnt_i;
    w_rsp_ok    = bus.obi_rvalid_i && (r_inflight != '0);
    w_spurious  = bus.obi_rvalid_i && (r_inflight == '0);
    w_pop       = (r_count != '0) && bus.rsp_ready_i;
    w_err_set   = w_spurious || (w_rsp_ok && (bus.obi_rid_i != r_exp_rid));

    w_req_d = r_req;
    if (w_accept) begin
      w_req_d = 1'b1;
    end else if (w_grant) begin
      w_req_d = 1'b0;
    end

    w_used_d = r_used;
    if (w_accept && !w_pop) begin
      w_used_d = r_used + CntWidth'(1);
    end else if (!w_accept && w_pop) begin
      w_used_d = r_used - CntWidth'(1);
    end

    w_inflight_d = r_inflight;
    if (w_grant && !w_rsp_ok) begin
      w_inflight_d = r_inflight + CntWidth'(1);
    end else if (!w_grant && w_rsp_ok) begin
      w_inflight_d = r_inflight - CntWidth'(1);
    end

    w_count_d = r_count;
    if (w_rsp_ok && !w_pop) begin
      w_count_d = r_count + CntWidth'(1);
    end else if (!w_rsp_ok && w_pop) begin
      w_count_d = r_count - CntWidth'(1);
    end

    w_wptr_d = r_wptr;
    if (w_rsp_ok) begin
      w_wptr_d = (r_wptr == LastPtr) ? '0 : r_wptr + PtrWidth'(1);
    end
    w_rptr_d = r_rptr;
    if (w_pop) begin
      w_rptr_d = (r_rptr == LastPtr) ? '0 : r_rptr + PtrWidth'(1);
    end

    w_proto_err_d = r_proto_err;
    if (w_err_set) begin
      w_proto_err_d = 1'b1;
    end else if (clr_err_i) begin
      w_proto_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_req       <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_be        <= '0;
      r_aid       <= '0;
      r_exp_rid   <= '0;
      r_used      <= '0;
      r_inflight  <= '0;
      r_count     <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_proto_err <= 1'b0;
      for (int unsigned i = 0; i < MaxOutstanding; i++) begin
        r_fifo_rdata[i] <= '0;
        r_fifo_err[i]   <= 1'b0;
      end
    end else begin
      r_req       <= w_req_d;
      r_used      <= w_used_d;
      r_inflight  <= w_inflight_d;
      r_count     <= w_count_d;
      r_wptr      <= w_wptr_d;
      r_rptr      <= w_rptr_d;
      r_proto_err <= w_proto_err_d;
      if (w_accept) begin
        r_we    <= bus.cmd_we_i;
        r_addr  <= bus.cmd_addr_i;
        r_wdata <= bus.cmd_wdata_i;
        r_be    <= bus.cmd_be_i;
      end
      // aid of the pending request is the counter itself; it advances once granted
      if (w_grant) begin
        r_aid <= r_aid + IdWidth'(1);
      end
      if (w_rsp_ok) begin
        r_exp_rid            <= r_exp_rid + IdWidth'(1);
        r_fifo_rdata[r_wptr] <= bus.obi_rdata_i;
        r_fifo_err[r_wptr]   <= bus.obi_err_i;
      end
    end
  end

  assign bus.cmd_ready_o = w_cmd_ready;
  assign bus.obi_req_o   = r_req;
  assign bus.obi_we_o    = r_we;
  assign bus.obi_addr_o  = r_addr;
  assign bus.obi_wdata_o = r_wdata;
  assign bus.obi_be_o    = r_be;
  assign bus.obi_aid_o   = r_aid;
  assign bus.rsp_valid_o = (r_count != '0);
  assign bus.rsp_rdata_o = r_fifo_rdata[r_rptr];
  assign bus.rsp_err_o   = r_fifo_err[r_rptr];
  assign proto_err_o     = r_proto_err;
  assign idle_o          = (r_used == '0);
endmodule

// File: tb/tb_dm_obi_initiator.sv
// Bench for dm_obi_initiator: directed scenarios, then randomized traffic against an
// in-order OBI responder model with a response scoreboard.
module tb_dm_obi_initiator;
  localparam int unsigned IdW    = 1;
  localparam int unsigned BW     = 32;
  localparam int unsigned MaxOut = 2;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        err;
    int unsigned seq;
  } txn_t;

  logic clk_i, rst_ni, clr_err_i, proto_err_o, idle_o;
  txn_t exp_q[$], addr_q[$], gnt_q[$];
  int   checks, failures, n_pops;
  bit   auto_en;
  logic m_gnt, m_rvalid, m_err, m_rready;
  logic [31:0]    m_rdata;
  logic [IdW-1:0] m_rid;

  dm_obi_initiator_if #(.IdWidth(IdW), .BusWidth(BW)) bus ();

  dm_obi_initiator #(.IdWidth(IdW), .BusWidth(BW), .MaxOutstanding(MaxOut)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .bus        (bus),
    .clr_err_i  (clr_err_i),
    .proto_err_o(proto_err_o),
    .idle_o     (idle_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s", name);
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_cmd(input logic v, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
    bus.cmd_valid_i = v;
    bus.cmd_we_i    = we;
    bus.cmd_addr_i  = addr;
    bus.cmd_wdata_i = wdata;
    bus.cmd_be_i    = be;
  endtask

  task automatic expect_rsp(input logic we, input logic [31:0] rdata, input logic err);
    txn_t t;
    t.we = we; t.addr = '0; t.wdata = '0; t.be = '0; t.rdata = rdata; t.err = err; t.seq = 0;
    exp_q.push_back(t);
  endtask

  // OBI responder side: manual values in directed tests, random in-order responder otherwise
  initial begin
    txn_t t;
    bus.obi_gnt_i = 0; bus.obi_rvalid_i = 0; bus.obi_rdata_i = '0;
    bus.obi_err_i = 0; bus.obi_rid_i = '0; bus.rsp_ready_i = 0;
    forever begin
      @(posedge clk_i);
      #2;
      if (auto_en) begin
        bus.obi_gnt_i   = ($urandom_range(99) < 60);
        bus.rsp_ready_i = ($urandom_range(99) < 70);
        if (gnt_q.size() > 0 && $urandom_range(1) == 1) begin
          t = gnt_q.pop_front();
          bus.obi_rvalid_i = 1'b1;
          bus.obi_rdata_i  = t.rdata;
          bus.obi_err_i    = t.err;
          bus.obi_rid_i    = IdW'(t.seq);
        end else begin
          bus.obi_rvalid_i = 1'b0;
          bus.obi_rdata_i  = $urandom;
          bus.obi_err_i    = 1'b0;
          bus.obi_rid_i    = '0;
        end
      end else begin
        bus.obi_gnt_i    = m_gnt;
        bus.obi_rvalid_i = m_rvalid;
        bus.obi_rdata_i  = m_rdata;
        bus.obi_err_i    = m_err;
        bus.obi_rid_i    = m_rid;
        bus.rsp_ready_i  = m_rready;
      end
    end
  end

  // Address-phase checker: each grant must carry the next issued command, aid = issue order
  initial begin
    txn_t t;
    forever begin
      @(negedge clk_i);
      if (auto_en && rst_ni && bus.obi_req_o && bus.obi_gnt_i) begin
        if (addr_q.size() == 0) begin
          fail_now("addr_phase unexpected grant");
        end else begin
          t = addr_q.pop_front();
          chk("addr_phase", 128'({bus.obi_we_o, bus.obi_be_o, bus.obi_addr_o, bus.obi_wdata_o,
                                  bus.obi_aid_o}),
              128'({t.we, t.be, t.addr, t.wdata, IdW'(t.seq)}));
          gnt_q.push_back(t);
        end
      end
    end
  end

  // Response scoreboard
  initial begin
    txn_t t;
    forever begin
      @(negedge clk_i);
      if (rst_ni && bus.rsp_valid_o && bus.rsp_ready_i) begin
        n_pops++;
        if (exp_q.size() == 0) begin
          fail_now("rsp unexpected response");
        end else begin
          t = exp_q.pop_front();
          if (t.we) chk("rsp_write_err", 128'(bus.rsp_err_o), 128'(t.err));
          else chk("rsp_read", 128'({bus.rsp_err_o, bus.rsp_rdata_o}), 128'({t.err, t.rdata}));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hung;
    checks = 0; failures = 0; n_pops = 0; auto_en = 0; hung = 0;
    m_gnt = 0; m_rvalid = 0; m_err = 0; m_rready = 0; m_rdata = '0; m_rid = '0;
    rst_ni = 0; clr_err_i = 0;
    set_cmd(0, 0, '0, '0, '0);

    // Reset values
    @(negedge clk_i);
    chk("rst_req", 128'(bus.obi_req_o), 128'(0));
    chk("rst_addr_phase", 128'({bus.obi_addr_o, bus.obi_we_o, bus.obi_be_o, bus.obi_wdata_o,
                                bus.obi_aid_o}), 128'(0));
    chk("rst_rsp", 128'({bus.rsp_valid_o, bus.rsp_rdata_o, bus.rsp_err_o}), 128'(0));
    chk("rst_status", 128'({proto_err_o, idle_o, bus.cmd_ready_o}), 128'(3'b011));
    cyc();
    rst_ni = 1;

    // Single read
    cyc(); set_cmd(1, 0, 32'h1000, '0, 4'hF); expect_rsp(0, 32'hDEADBEEF, 0);
    @(negedge clk_i); chk("t1_ready", 128'(bus.cmd_ready_o), 128'(1));
    cyc(); set_cmd(0, 0, '0, '0, '0); m_gnt = 1;
    @(negedge clk_i);
    chk("t1_req", 128'({bus.obi_req_o, bus.obi_we_o, bus.obi_addr_o, bus.obi_aid_o}),
        128'({1'b1, 1'b0, 32'h1000, 1'b0}));
    cyc(); m_gnt = 0; m_rvalid = 1; m_rdata = 32'hDEADBEEF; m_rid = '0; m_err = 0;
    @(negedge clk_i); chk("t1_no_bypass", 128'(bus.rsp_valid_o), 128'(0));
    cyc(); m_rvalid = 0; m_rready = 1;
    @(negedge clk_i); chk("t1_rsp_valid", 128'(bus.rsp_valid_o), 128'(1));
    cyc(); m_rready = 0;
    @(negedge clk_i); chk("t1_idle", 128'({idle_o, bus.rsp_valid_o, proto_err_o}), 128'(3'b100));

    // Grant stall
    cyc(); set_cmd(1, 1, 32'h2004, 32'h55AA, 4'hF); expect_rsp(1, '0, 0);
    @(negedge clk_i); chk("t2_ready", 128'(bus.cmd_ready_o), 128'(1));
    cyc(); set_cmd(0, 0, '0, '0, '0); m_gnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("t2_stable", 128'({bus.obi_req_o, bus.cmd_ready_o, bus.obi_addr_o, bus.obi_we_o,
                             bus.obi_wdata_o, bus.obi_be_o, bus.obi_aid_o}),
          128'({1'b1, 1'b0, 32'h2004, 1'b1, 32'h55AA, 4'hF, 1'b1}));
      cyc();
    end
    m_gnt = 1;
    cyc(); m_gnt = 0; m_rvalid = 1; m_rid = IdW'(1); m_rdata = 32'h0;
    cyc(); m_rvalid = 0; m_rready = 1;
    @(negedge clk_i); chk("t2_rsp_valid", 128'(bus.rsp_valid_o), 128'(1));
    cyc(); m_rready = 0;

    // Credit limit, MaxOutstanding = 2
    cyc(); set_cmd(1, 0, 32'h3000, '0, 4'hF); expect_rsp(0, 32'h11111111, 0);
    @(negedge clk_i); chk("t3_ready_a", 128'(bus.cmd_ready_o), 128'(1));
    cyc(); set_cmd(1, 0, 32'h3004, '0, 4'hF); m_gnt = 1; expect_rsp(0, 32'h22222222, 0);
    @(negedge clk_i); chk("t3_ready_b_aid0", 128'({bus.cmd_ready_o, bus.obi_aid_o}), 128'(2'b10));
    cyc(); set_cmd(1, 0, 32'h3008, '0, 4'hF);
    @(negedge clk_i);
    chk("t3_full_aid1", 128'({bus.cmd_ready_o, bus.obi_req_o, bus.obi_aid_o}), 128'(3'b011));
    cyc(); m_gnt = 0; m_rvalid = 1; m_rdata = 32'h11111111; m_rid = '0;
    @(negedge clk_i); chk("t3_blocked_1", 128'({bus.cmd_ready_o, bus.obi_req_o}), 128'(0));
    cyc(); m_rdata = 32'h22222222; m_rid = IdW'(1);
    @(negedge clk_i); chk("t3_blocked_2", 128'(bus.cmd_ready_o), 128'(0));
    cyc(); m_rvalid = 0; m_rready = 1;
    @(negedge clk_i); chk("t3_pop_no_bypass", 128'({bus.rsp_valid_o, bus.cmd_ready_o}), 128'(2'b10));
    cyc(); m_rready = 0; expect_rsp(0, 32'h33333333, 0);
    @(negedge clk_i); chk("t3_ready_after_pop", 128'(bus.cmd_ready_o), 128'(1));
    cyc(); set_cmd(0, 0, '0, '0, '0); m_gnt = 1;
    @(negedge clk_i);
    chk("t3_third_aid0", 128'({bus.obi_req_o, bus.obi_aid_o, bus.obi_addr_o}),
        128'({1'b1, 1'b0, 32'h3008}));
    cyc(); m_gnt = 0; m_rvalid = 1; m_rdata = 32'h33333333; m_rid = '0;
    cyc(); m_rvalid = 0; m_rready = 1;
    repeat (3) cyc();
    @(negedge clk_i);
    chk("t3_drained", 128'({idle_o, proto_err_o, 32'(exp_q.size())}), 128'({1'b1, 1'b0, 32'd0}));

    // Back-to-back with grant held high, err on the second response
    cyc(); set_cmd(1, 1, 32'h4000, 32'hAAAA0001, 4'h3); m_gnt = 1; expect_rsp(1, '0, 0);
    @(negedge clk_i); chk("t4_ready_1", 128'(bus.cmd_ready_o), 128'(1));
    cyc(); set_cmd(1, 0, 32'h4004, '0, 4'hF); expect_rsp(0, 32'hCAFEF00D, 1);
    @(negedge clk_i);
    chk("t4_req_1", 128'({bus.cmd_ready_o, bus.obi_req_o, bus.obi_addr_o, bus.obi_aid_o}),
        128'({1'b1, 1'b1, 32'h4000, 1'b1}));
    cyc(); set_cmd(0, 0, '0, '0, '0); m_rvalid = 1; m_rdata = '0; m_err = 0; m_rid = IdW'(1);
    @(negedge clk_i);
    chk("t4_req_2", 128'({bus.obi_req_o, bus.obi_addr_o, bus.obi_aid_o}),
        128'({1'b1, 32'h4004, 1'b0}));
    cyc(); m_rdata = 32'hCAFEF00D; m_err = 1; m_rid = '0;
    cyc(); m_rvalid = 0; m_err = 0; m_gnt = 0;
    repeat (2) cyc();
    @(negedge clk_i);
    chk("t4_drained", 128'({idle_o, proto_err_o, 32'(exp_q.size())}), 128'({1'b1, 1'b0, 32'd0}));

    // Protocol errors: wrong rid, spurious rvalid, clear, set-wins
    cyc(); set_cmd(1, 0, 32'h5000, '0, 4'hF); expect_rsp(0, 32'h12345678, 0);
    cyc(); set_cmd(0, 0, '0, '0, '0); m_gnt = 1;
    cyc(); m_gnt = 0; m_rvalid = 1; m_rdata = 32'h12345678; m_rid = '0;
    cyc(); m_rvalid = 0;
    @(negedge clk_i);
    chk("t5_rid_err_delivered", 128'({proto_err_o, bus.rsp_valid_o}), 128'(2'b11));
    cyc(); clr_err_i = 1;
    cyc(); clr_err_i = 0;
    @(negedge clk_i); chk("t5_cleared", 128'(proto_err_o), 128'(0));
    cyc(); m_rvalid = 1; m_rdata = 32'hBAD; m_rid = '0;
    cyc(); m_rvalid = 0;
    @(negedge clk_i);
    chk("t5_spurious", 128'({proto_err_o, bus.rsp_valid_o, idle_o}), 128'(3'b101));
    cyc(); clr_err_i = 1; m_rvalid = 1;
    cyc(); clr_err_i = 0; m_rvalid = 0;
    @(negedge clk_i); chk("t5_set_wins", 128'(proto_err_o), 128'(1));
    cyc(); clr_err_i = 1;
    cyc(); clr_err_i = 0;
    @(negedge clk_i); chk("t5_cleared_2", 128'(proto_err_o), 128'(0));

    // Reset with a request pending and one response in flight
    cyc(); set_cmd(1, 0, 32'h6000, '0, 4'hF);
    cyc(); set_cmd(1, 0, 32'h6004, '0, 4'hF); m_gnt = 1;
    @(negedge clk_i); chk("t6_ready", 128'(bus.cmd_ready_o), 128'(1));
    cyc(); set_cmd(0, 0, '0, '0, '0); m_gnt = 0;
    @(negedge clk_i); chk("t6_pending", 128'(bus.obi_req_o), 128'(1));
    #1 rst_ni = 0;
    #1 chk("t6_req_async_drop", 128'({bus.obi_req_o, idle_o}), 128'(2'b01));
    exp_q.delete();
    cyc(); rst_ni = 1;
    @(negedge clk_i);
    chk("t6_after_rst", 128'({idle_o, bus.cmd_ready_o, bus.obi_aid_o, proto_err_o}),
        128'(4'b1100));
    cyc(); m_rvalid = 1; m_rdata = 32'h5A5A; m_rid = '0;
    cyc(); m_rvalid = 0;
    @(negedge clk_i); chk("t6_stale_rvalid", 128'({proto_err_o, bus.rsp_valid_o}), 128'(2'b10));
    cyc(); clr_err_i = 1;
    cyc(); clr_err_i = 0;

    // Randomized traffic; counters restarted at 0 by the reset above
    auto_en = 1;
    for (int n = 0; n < 150 && !hung; n++) begin
      txn_t t;
      int   w;
      t.we = 1'($urandom_range(1)); t.addr = $urandom; t.wdata = $urandom;
      t.be = 4'($urandom_range(15)); t.rdata = $urandom; t.err = ($urandom_range(9) == 0);
      t.seq = unsigned'(n);
      set_cmd(1, t.we, t.addr, t.wdata, t.be);
      w = 0;
      forever begin
        @(negedge clk_i);
        if (bus.cmd_ready_o) break;
        w++;
        if (w > 200) begin
          fail_now("rand cmd_ready timeout");
          hung = 1;
          break;
        end
        cyc();
      end
      if (!hung) begin
        exp_q.push_back(t);
        addr_q.push_back(t);
        cyc();
        set_cmd(0, 0, '0, '0, '0);
        repeat ($urandom_range(1)) cyc();
      end
    end
    set_cmd(0, 0, '0, '0, '0);
    for (int w = 0; w < 1000 && (exp_q.size() != 0 || !idle_o); w++) cyc();
    @(negedge clk_i);
    chk("rand_drained", 128'({idle_o, proto_err_o, 32'(exp_q.size()), 32'(addr_q.size())}),
        128'({1'b1, 1'b0, 32'd0, 32'd0}));
    chk("rand_pop_count_min", 128'(n_pops >= 150), 128'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
